// File: rtl/gpio_in_capture_if.sv
// gpio_in_capture_if
// CPU-side read bus of the GPIO input capture block.
//   rd            : single-cycle read strobe from the CPU, clears the sticky flags
//   gpio_in       : 32-bit status word presented to the CPU
//   event_pending : OR of all sticky press flags and the switch-change flag
// Modports:
//   master : CPU side (drives rd, reads status)
//   slave  : capture block side (receives rd, drives status)
interface gpio_in_capture_if;

    logic        rd;
    logic [31:0] gpio_in;
    logic        event_pending;

    modport master (
        output rd,
        input  gpio_in,
        input  event_pending
    );

    modport slave (
        input  rd,
        output gpio_in,
        output event_pending
    );

endinterface

// File: rtl/gpio_in_capture.sv
// gpio_in_capture
// Synchronizes and debounces board switches and push-buttons, records sticky
// button-press and switch-change events, and presents everything as one
// 32-bit word on the CPU gpio_in bus.
// Ports:
//   clk     : system clock
//   res     : asynchronous, active-high reset
//   sw_raw  : raw switch levels, asynchronous to clk
//   key_raw : raw button levels, active-low at the pins (0 = pressed)
//   bus     : CPU read bus (rd strobe in, gpio_in / event_pending out)
// gpio_in layout:
//   [17:0] stable switches, [21:18] stable keys (1 = pressed),
//   [25:22] press events, [30:26] zero, [31] switch-changed flag.
module gpio_in_capture #(
    parameter int unsigned SW_W            = 18,
    parameter int unsigned KEY_W           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [SW_W-1:0]      sw_raw,
    input  logic [KEY_W-1:0]     key_raw,
    gpio_in_capture_if.slave     bus
);

    localparam int unsigned NumIn = SW_W + KEY_W;
    localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    // Field widths actually mapped into gpio_in; narrower configs pad with 0.
    localparam int unsigned SwN  = (SW_W < 18) ? SW_W : 18;
    localparam int unsigned KeyN = (KEY_W < 4) ? KEY_W : 4;

    // ------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------
    logic [SW_W-1:0]  sw_s1_q,  sw_s1_d;
    logic [SW_W-1:0]  sw_s2_q,  sw_s2_d;
    logic [KEY_W-1:0] key_s1_q, key_s1_d;
    logic [KEY_W-1:0] key_s2_q, key_s2_d;

    always_comb begin
        sw_s1_d  = sw_raw;
        sw_s2_d  = sw_s1_q;
        key_s1_d = key_raw;
        key_s2_d = key_s1_q;
    end

    // Keys are flipped here so every later stage sees 1 = pressed.
    logic [NumIn-1:0] in_s2;
    assign in_s2 = {~key_s2_q, sw_s2_q};

    // ------------------------------------------------------------------
    // Per-bit debounce: one counter per input bit
    // ------------------------------------------------------------------
    logic [NumIn-1:0] stable_q, stable_d;
    logic [CntW-1:0]  cnt_q [NumIn];
    logic [CntW-1:0]  cnt_d [NumIn];
    logic [NumIn-1:0] accept;

    always_comb begin
        stable_d = stable_q;
        accept   = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            // Any cycle agreeing with the stable level restarts the count,
            // which is what throws away short glitches.
            cnt_d[i] = '0;
            if (in_s2[i] != stable_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    accept[i]   = 1'b1;
                    stable_d[i] = in_s2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky event flags (set wins over a same-edge read clear)
    // ------------------------------------------------------------------
    logic [KEY_W-1:0] press_evt_q, press_evt_d;
    logic             sw_changed_q, sw_changed_d;
    logic [KEY_W-1:0] key_rise;
    logic             sw_update;

    always_comb begin
        // Only an accepted transition to 1 (released -> pressed) is an event.
        key_rise     = accept[NumIn-1:SW_W] & stable_d[NumIn-1:SW_W];
        sw_update    = |accept[SW_W-1:0];
        press_evt_d  = key_rise | (press_evt_q & ~{KEY_W{bus.rd}});
        sw_changed_d = sw_update | (sw_changed_q & ~bus.rd);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            key_s1_q     <= '1;
            key_s2_q     <= '1;
            stable_q     <= '0;
            press_evt_q  <= '0;
            sw_changed_q <= 1'b0;
            for (int i = 0; i < int'(NumIn); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sw_s1_q      <= sw_s1_d;
            sw_s2_q      <= sw_s2_d;
            key_s1_q     <= key_s1_d;
            key_s2_q     <= key_s2_d;
            stable_q     <= stable_d;
            press_evt_q  <= press_evt_d;
            sw_changed_q <= sw_changed_d;
            for (int i = 0; i < int'(NumIn); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Status word, straight from registers so a read sees pre-clear flags
    // ------------------------------------------------------------------
    logic [17:0] sw_field;
    logic [3:0]  key_field;
    logic [3:0]  evt_field;

    always_comb begin
        sw_field  = '0;
        key_field = '0;
        evt_field = '0;
        sw_field[SwN-1:0]   = stable_q[SwN-1:0];
        key_field[KeyN-1:0] = stable_q[SW_W +: KeyN];
        evt_field[KeyN-1:0] = press_evt_q[KeyN-1:0];
        bus.gpio_in         = {sw_changed_q, 5'b0_0000, evt_field, key_field, sw_field};
        bus.event_pending   = (|press_evt_q) | sw_changed_q;
    end

endmodule

// File: doc/gpio_in_capture.md
Name: gpio_in_capture

Overview:
- Input-side counterpart to the CPU's GPIO output path.
- Synchronizes and debounces the board switches (SW) and push-buttons (KEY).
- Records button-press events and switch-change events in sticky flags that the CPU clears by reading.
- Presents one 32-bit word on the CPU's gpio_in bus, replacing the direct SW-to-gpio_in wiring in the board top.

Parameters:
- SW_W, 18, number of switch inputs.
- KEY_W, 4, number of push-button inputs (active-low at the pins).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a new input level is accepted; legal range 2..255; counter width = clog2(DEBOUNCE_CYCLES).

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- res  input  1  asynchronous, active-high reset.
- sw_raw  input  SW_W  raw switch levels, asynchronous to clk.
- key_raw  input  KEY_W  raw button levels, active-low (0 = pressed), asynchronous to clk.
- rd  input  1  single-cycle read strobe from the CPU GPIO read; clears the sticky flags.
- gpio_in  output  32  status word read by the CPU.
- event_pending  output  1  OR of all sticky press flags and the change flag.

Behaviour:
- Synchronizer: two-flop chain per bit.
  - sw chain resets to 0.
  - key chain resets to 1 (released).
  - Keys are inverted after synchronization, so internally 1 = pressed.
- Debounce: one counter per input bit (SW_W + KEY_W counters), operating on the second sync stage s2 against a stable register.
  - Each edge where s2 != stable: counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s2 still != stable: stable <= s2 and counter <= 0 on that edge.
  - Any edge where s2 == stable: counter <= 0, so glitches shorter than DEBOUNCE_CYCLES cycles are discarded.
  - Latency: a raw level change set up before edge 1 is reflected in stable and in gpio_in immediately after edge 2+DEBOUNCE_CYCLES (edge 18 at default). No earlier update is allowed.
- Sticky flags:
  - press_evt[i] is set on the edge where stable key i goes 0->1. Release transitions set nothing.
  - sw_changed is set on any edge where any stable SW bit updates.
  - rd=1 at an edge clears press_evt and sw_changed on that edge.
  - Set has priority: if a set condition occurs on the same edge as rd, the flag ends that edge set.
  - Repeated events before a read leave the flag at 1; there is no counting.
- gpio_in mapping, driven combinationally from registers (no extra cycle):
  - [17:0] = stable SW.
  - [21:18] = stable keys, 1 = pressed.
  - [25:22] = press_evt.
  - [30:26] = 0.
  - [31] = sw_changed.
  - If SW_W or KEY_W are smaller than the defaults, the unused field bits read 0.
- The value of gpio_in sampled by the CPU in the rd cycle is the pre-clear value.
- Reset (asynchronous, any time, including mid-debounce):
  - All counters, stable SW, stable keys (released), press_evt and sw_changed go to 0.
  - gpio_in = 32'h0 and event_pending = 0 while res is high and after release, until an input differs.
  - A debounce in progress when reset asserts is abandoned. The input must be stable for a full DEBOUNCE_CYCLES after reset releases to be accepted.
- No other state. Each bit is independent; simultaneous changes on several bits all resolve on their own counters.

Test Plan:
- Reset with KEY=4'hF, SW=0 → gpio_in=32'h0000_0000 and event_pending=0 through 30 cycles after res deassert.
- Set SW=18'h00005 before edge 1 and hold → gpio_in stays 0 through edge 17; after edge 18 gpio_in=32'h8000_0005; then rd pulse → gpio_in=32'h0000_0005, event_pending=0.
- Toggle SW[3] high for 10 cycles, then low (glitch < 16) → gpio_in unchanged at 0 throughout, sw_changed never set.
- Hold KEY[0]=0 for 20 cycles, then release → after edge 18 gpio_in=32'h0044_0000 (bit 18 pressed, bit 22 event); 18 edges after release gpio_in=32'h0040_0000; rd → 32'h0.
- rd asserted on the same edge that KEY[1]'s stable value goes pressed → bit 23 is set after that edge (set wins); a second rd → bit 23 cleared while bit 19 stays 1.
- Assert res while SW[0] has been high for 10 cycles (mid-count) → gpio_in=0 immediately; after res release with SW[0] still high, bit 0 appears exactly 2+16 edges later, together with bit 31.
